// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI slave exposing a small register file.
// Frame = one command word, then any number of data words (WORD_W bits each, MSB first).
// Command: MSB=0 write, MSB=1 read; low ADDR_W bits select the start register.
// Define SPI_REGFILE_AUTOINC_EN to advance the register pointer after every data word;
// left undefined, a frame keeps hitting the register its command selected.
// A frame is only honoured after CS_n has been seen going high then low since reset.
// Current FSM state is visible on o_Dbg_State for checkers.
module spi_slave_regfile #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                      i_Rst_L,
  input  logic                      w_SPI_Clk,
  input  logic                      i_SPI_CS_n,
  input  logic                      i_SPI_MOSI,
  output logic                      o_SPI_MISO,
  output logic [DEPTH*WORD_W-1:0]   o_Reg_Flat,
  output logic [ADDR_W-1:0]         o_Wr_Addr,
  output logic                      o_Wr_Toggle,
  output logic                      o_Frame_Active,
  output logic [1:0]                o_Dbg_State
);

  localparam int CNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    S_CMD = 2'd0,
    S_WR  = 2'd1,
    S_RD  = 2'd2
  } state_t;

  state_t              r_State;
  state_t              w_State_Next;
  logic [CNT_W-1:0]    r_Bit_Cnt;
  logic [WORD_W-1:0]   r_Tx;
  logic [WORD_W-2:0]   r_Shift;
  logic [ADDR_W-1:0]   r_Ptr;
  logic [WORD_W-1:0]   r_Regs [DEPTH];
  logic                r_Armed;
  logic                r_Frame_Active;
  logic                r_Wr_Toggle;
  logic [ADDR_W-1:0]   r_Wr_Addr;

  logic                w_Edge_En;
  logic                w_Last;
  logic [WORD_W-1:0]   w_Word;
  logic [ADDR_W-1:0]   w_Cmd_Addr;
  logic                w_Cmd_Rd;
  logic [ADDR_W-1:0]   w_Ptr_Step;
  logic [ADDR_W-1:0]   w_Cmd_Step;
  logic                w_Do_Write;
  logic                w_Load_Tx;
  logic [ADDR_W-1:0]   w_Tx_Addr;

  // An edge only counts while selected and after a fresh CS_n fall since reset.
  assign w_Edge_En  = !i_SPI_CS_n && r_Armed;
  assign w_Last     = (r_Bit_Cnt == CNT_W'(WORD_W - 1));
  // Word completed by the bit sampled on the current edge.
  assign w_Word     = {r_Shift, i_SPI_MOSI};
  assign w_Cmd_Addr = w_Word[ADDR_W-1:0];
  assign w_Cmd_Rd   = w_Word[WORD_W-1];

`ifdef SPI_REGFILE_AUTOINC_EN
  assign w_Ptr_Step = r_Ptr + ADDR_W'(1);
  assign w_Cmd_Step = w_Cmd_Addr + ADDR_W'(1);
`else
  assign w_Ptr_Step = r_Ptr;
  assign w_Cmd_Step = w_Cmd_Addr;
`endif

  // Arm on each CS_n fall; a frame already in progress at reset release is ignored.
  always_ff @(negedge i_SPI_CS_n or negedge i_Rst_L) begin
    if (!i_Rst_L) r_Armed <= 1'b0;
    else          r_Armed <= 1'b1;
  end

  // Next-state decode plus write/TX-load strobes for the current edge.
  always_comb begin
    w_State_Next = r_State;
    w_Do_Write   = 1'b0;
    w_Load_Tx    = 1'b0;
    w_Tx_Addr    = r_Ptr;
    case (r_State)
      S_CMD: begin
        if (w_Last) begin
          w_State_Next = w_Cmd_Rd ? S_RD : S_WR;
          w_Load_Tx    = w_Cmd_Rd;
          w_Tx_Addr    = w_Cmd_Addr;
        end
      end
      S_WR:    w_Do_Write   = w_Last;
      S_RD:    w_Load_Tx    = w_Last;
      default: w_State_Next = S_CMD;
    endcase
  end

  // Frame-scoped state: reset and CS_n high both abort back to the command phase.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
    if (!i_Rst_L) begin
      r_State        <= S_CMD;
      r_Bit_Cnt      <= '0;
      r_Tx           <= '0;
      r_Frame_Active <= 1'b0;
    end else if (i_SPI_CS_n) begin
      r_State        <= S_CMD;
      r_Bit_Cnt      <= '0;
      r_Tx           <= '0;
      r_Frame_Active <= 1'b0;
    end else if (r_Armed) begin
      r_State        <= w_State_Next;
      r_Bit_Cnt      <= w_Last ? '0 : r_Bit_Cnt + CNT_W'(1);
      r_Frame_Active <= 1'b1;
      if (w_Load_Tx) r_Tx <= r_Regs[w_Tx_Addr];
      else           r_Tx <= {r_Tx[WORD_W-2:0], 1'b0};
    end
  end

  // Persistent state: survives CS_n aborts, cleared only by reset.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < DEPTH; i++) r_Regs[i] <= '0;
      r_Shift     <= '0;
      r_Ptr       <= '0;
      r_Wr_Addr   <= '0;
      r_Wr_Toggle <= 1'b0;
    end else if (w_Edge_En) begin
      r_Shift <= w_Word[WORD_W-2:0];
      if (r_State == S_CMD && w_Last) begin
        // Writes commit at the pointer first; reads already consumed it for TX.
        r_Ptr <= w_Cmd_Rd ? w_Cmd_Step : w_Cmd_Addr;
      end
      if (w_Do_Write) begin
        r_Regs[r_Ptr] <= w_Word;
        r_Wr_Addr     <= r_Ptr;
        r_Wr_Toggle   <= ~r_Wr_Toggle;
        r_Ptr         <= w_Ptr_Step;
      end
      if (w_Load_Tx && r_State == S_RD) r_Ptr <= w_Ptr_Step;
    end
  end

  // Flatten the register array for system-side consumers.
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign o_Reg_Flat[g*WORD_W +: WORD_W] = r_Regs[g];
  end

  assign o_SPI_MISO     = i_SPI_CS_n ? 1'b1 :
                          (r_State == S_RD) ? r_Tx[WORD_W-1] : 1'b0;
  assign o_Wr_Addr      = r_Wr_Addr;
  assign o_Wr_Toggle    = r_Wr_Toggle;
  assign o_Frame_Active = r_Frame_Active;
  assign o_Dbg_State    = r_State;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile (WORD_W=8, DEPTH=16); expectations follow
// SPI_REGFILE_AUTOINC_EN as defined for the build.
module tb_spi_slave_regfile;
  localparam int WORD_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef SPI_REGFILE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic                    clk   = 1'b0;
  logic                    rst_l = 1'b0;
  logic                    cs_n  = 1'b1;
  logic                    mosi  = 1'b0;
  logic                    miso;
  logic [DEPTH*WORD_W-1:0] reg_flat;
  logic [ADDR_W-1:0]       wr_addr;
  logic                    wr_toggle;
  logic                    frame_active;
  logic [1:0]              dbg_state;

  spi_slave_regfile #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .i_Rst_L        (rst_l),
    .w_SPI_Clk      (clk),
    .i_SPI_CS_n     (cs_n),
    .i_SPI_MOSI     (mosi),
    .o_SPI_MISO     (miso),
    .o_Reg_Flat     (reg_flat),
    .o_Wr_Addr      (wr_addr),
    .o_Wr_Toggle    (wr_toggle),
    .o_Frame_Active (frame_active),
    .o_Dbg_State    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [ADDR_W+WORD_W-1:0] exp_q[$];     // expected writes {addr, data}
  logic [WORD_W-1:0]        exp_rd_q[$];  // expected MISO bytes
  logic [WORD_W-1:0]        act_rd_q[$];  // MISO bytes captured from the DUT
  logic                     exp_toggle = 1'b0;
  logic                     prev_toggle = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] reg_word(input int a);
    return reg_flat[a*WORD_W +: WORD_W];
  endfunction

  // Write monitor: every o_Wr_Toggle flip must match the next expected write.
  always @(posedge clk) begin : wr_mon
    logic [ADDR_W+WORD_W-1:0] e;
    #1;
    if (!rst_l) begin
      prev_toggle = wr_toggle;
    end else if (wr_toggle !== prev_toggle) begin
      prev_toggle = wr_toggle;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: actual addr=%0d required=no write", wr_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+WORD_W-1:WORD_W]));
        check("wr_data", 32'(reg_word(int'(e[ADDR_W+WORD_W-1:WORD_W]))), 32'(e[WORD_W-1:0]));
      end
    end
  end

  // MISO monitor: compare each captured byte against the expected queue.
  always @(negedge clk) begin : rd_mon
    logic [WORD_W-1:0] a;
    while (act_rd_q.size() > 0) begin
      a = act_rd_q.pop_front();
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL miso_unexpected: actual=0x%0h required=none", a);
      end else begin
        check("miso_byte", 32'(a), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_write(input int a, input logic [7:0] d);
    exp_q.push_back({ADDR_W'(a), d});
    exp_toggle = ~exp_toggle;
  endtask

  // Drive nbits of b MSB first; MISO is sampled before each sampling edge.
  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk);
      cs_n = 1'b0;
      mosi = b[i];
      #1;
      rx[i] = miso;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_rx);
    logic [7:0] rx;
    exp_rd_q.push_back(exp_rx);
    send_bits(b, 8, rx);
    act_rd_q.push_back(rx);
  endtask

  task automatic end_frame();
    @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    #1;
  endtask

  task automatic frame(input int n,
                       input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
    send_byte(b0, r0);
    if (n > 1) send_byte(b1, r1);
    if (n > 2) send_byte(b2, r2);
    end_frame();
  endtask

  task automatic check_reset_state(input string tag, input logic exp_miso);
    for (int i = 0; i < DEPTH; i++) check({tag, "_reg_zero"}, 32'(reg_word(i)), 32'h0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'h0);
    check({tag, "_toggle"}, 32'(wr_toggle), 32'h0);
    check({tag, "_frame_active"}, 32'(frame_active), 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'h0);
    check({tag, "_miso"}, 32'(miso), 32'(exp_miso));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] junk;

    // Reset with CS_n high.
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("rst", 1'b1);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    // Write frame 0x03,0xAA,0x55.
    expect_write(3, 8'hAA);
    expect_write(AUTOINC ? 4 : 3, 8'h55);
    send_byte(8'h03, 8'h00);
    check("frame_active_mid", 32'(frame_active), 32'h1);
    send_byte(8'hAA, 8'h00);
    send_byte(8'h55, 8'h00);
    end_frame();
    check("frame_active_end", 32'(frame_active), 32'h0);
    check("miso_idle", 32'(miso), 32'h1);
    check("reg3", 32'(reg_word(3)), AUTOINC ? 32'hAA : 32'h55);
    check("reg4", 32'(reg_word(4)), AUTOINC ? 32'h55 : 32'h00);
    check("wr_addr_f1", 32'(wr_addr), AUTOINC ? 32'h4 : 32'h3);
    check("toggle_f1", 32'(wr_toggle), 32'(exp_toggle));

    // Read back from register 3.
    frame(3, 8'h83, 8'h00, 8'h00, 8'h00, AUTOINC ? 8'hAA : 8'h55, 8'h55);

    // Pointer wrap 15 -> 0.
    expect_write(15, 8'h11);
    expect_write(AUTOINC ? 0 : 15, 8'h22);
    frame(3, 8'h0F, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00);
    check("reg15", 32'(reg_word(15)), AUTOINC ? 32'h11 : 32'h22);
    check("reg0", 32'(reg_word(0)), AUTOINC ? 32'h22 : 32'h00);
    frame(3, 8'h8F, 8'hC3, 8'h3C, 8'h00, AUTOINC ? 8'h11 : 8'h22, 8'h22);

    // Abort mid-word: command 0x05 then 4 bits of ones.
    send_byte(8'h05, 8'h00);
    send_bits(8'hFF, 4, junk);
    end_frame();
    check("abort_reg5", 32'(reg_word(5)), 32'h0);
    check("abort_toggle", 32'(wr_toggle), 32'(exp_toggle));
    check("abort_wr_addr", 32'(wr_addr), AUTOINC ? 32'h0 : 32'hF);
    check("abort_frame_active", 32'(frame_active), 32'h0);
    check("abort_state", 32'(dbg_state), 32'h0);
    expect_write(6, 8'h77);
    frame(2, 8'h06, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00);
    check("fresh_reg6", 32'(reg_word(6)), 32'h77);
    check("fresh_reg5", 32'(reg_word(5)), 32'h0);

    // Repeated writes from address 2.
    expect_write(2, 8'h10);
    expect_write(AUTOINC ? 3 : 2, 8'h20);
    frame(3, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00);
    check("reg2", 32'(reg_word(2)), AUTOINC ? 32'h10 : 32'h20);
    check("reg3_after", 32'(reg_word(3)), AUTOINC ? 32'h20 : 32'h55);
    check("toggle_pre_rst", 32'(wr_toggle), 32'(exp_toggle));

    // Reset during a read data word, CS_n held low.
    send_byte(8'h83, 8'h00);
    send_bits(8'h00, 3, junk);
    @(negedge clk);
    rst_l = 1'b0;
    exp_toggle = 1'b0;
    #1;
    check_reset_state("rst_mid", 1'b0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    // CS_n never rose: these edges must be ignored.
    send_bits(8'h01, 8, junk);
    send_bits(8'hFF, 8, junk);
    check("stale_reg1", 32'(reg_word(1)), 32'h0);
    check("stale_toggle", 32'(wr_toggle), 32'h0);
    check("stale_frame_active", 32'(frame_active), 32'h0);
    end_frame();
    check("miso_cs_high", 32'(miso), 32'h1);
    expect_write(1, 8'h5A);
    frame(2, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00);
    check("post_rst_reg1", 32'(reg_word(1)), 32'h5A);
    check("post_rst_wr_addr", 32'(wr_addr), 32'h1);
    check("post_rst_toggle", 32'(wr_toggle), 32'(exp_toggle));

    repeat (4) @(negedge clk);
    check("wr_q_drained", 32'(exp_q.size()), 32'h0);
    check("rd_q_drained", 32'(exp_rd_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 Parameter WORD_W, default 8, meaning SPI word width in bits; legal range 8..32.
REQ-002 Parameter DEPTH, default 16, meaning number of register words; power of two, 2..256; ADDR_W = log2(DEPTH), with ADDR_W <= WORD_W-1.
REQ-003 i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-004 w_SPI_Clk  input  1  clock, already polarity/phase-adjusted SPI clock; MOSI sampled and MISO updated on its rising edge.
REQ-005 i_SPI_CS_n  input  1  chip select, active-low; high asynchronously aborts the frame.
REQ-006 i_SPI_MOSI  input  1  serial data in, MSB first.
REQ-007 o_SPI_MISO  output  1  serial data out, MSB first; driven 1 while i_SPI_CS_n high.
REQ-008 o_Reg_Flat  output  DEPTH*WORD_W  register file contents; word n at bits [n*WORD_W +: WORD_W].
REQ-009 o_Wr_Addr  output  ADDR_W  address of the most recent completed write.
REQ-010 o_Wr_Toggle  output  1  inverts once per completed register write, for edge detection in the system clock domain.
REQ-011 o_Frame_Active  output  1  high from the first sampled bit of a frame until CS_n deasserts.

Function
REQ-012 Frame structure: one command word, then zero or more data words, each WORD_W bits; bit counter runs 0..WORD_W-1 and wraps.
REQ-013 FSM states: S_CMD (reset/abort state), S_WR, S_RD.
REQ-014 In S_CMD, the edge sampling bit WORD_W-1 decodes cmd = {shift[WORD_W-2:0], MOSI}: cmd[WORD_W-1]=0 -> S_WR, =1 -> S_RD; ptr <= cmd[ADDR_W-1:0]; other bits are ignored.
REQ-015 In S_WR, the edge sampling the last bit of a word writes reg[ptr] <= completed word, sets o_Wr_Addr <= ptr, inverts o_Wr_Toggle and advances ptr; o_Reg_Flat reflects the write after that edge.
REQ-016 On the S_CMD->S_RD edge, the TX shift register loads reg[cmd addr] and ptr advances; o_SPI_MISO shows bit WORD_W-1 of that word immediately after this edge.
REQ-017 In S_RD, each subsequent edge shifts TX left by one; the last-bit edge of each word reloads TX from reg[ptr] and advances ptr; MOSI data is ignored.
REQ-018 During S_CMD and S_WR, o_SPI_MISO = 0 while CS_n low.
REQ-019 ptr advances modulo DEPTH: DEPTH-1 wraps to 0, for both reads and writes.
REQ-020 A rising edge of i_SPI_CS_n mid-word asynchronously returns the FSM to S_CMD, clears the bit counter, TX register and o_Frame_Active, and discards the partial word; register contents, o_Wr_Addr and o_Wr_Toggle are kept.
REQ-021 Edges with CS_n high have no effect.
REQ-022 A frame ending exactly on a word boundary has committed all completed words.

Reset
REQ-023 i_Rst_L low asynchronously clears: all registers to 0, o_Wr_Addr 0, o_Wr_Toggle 0, ptr 0, bit counter 0, FSM S_CMD, o_Frame_Active 0, TX register 0.
REQ-024 Reset has priority over CS_n abort; reset during a frame discards it; after release, the next frame starts at S_CMD only once CS_n is seen high then low.

Configuration
REQ-025 Macro SPI_REGFILE_AUTOINC_EN: when defined, ptr advances per REQ-015..REQ-019; when undefined, ptr stays at the command address for the whole frame (repeated writes and reads hit one register).

Verification
REQ-026 WORD_W=8, DEPTH=16, AUTOINC on: frame 0x03,0xAA,0x55 -> reg3=0xAA, reg4=0x55, o_Wr_Addr=4, o_Wr_Toggle toggled twice.
REQ-027 Following frame 0x83,0x00,0x00 -> MISO bytes 0x00,0xAA,0x55.
REQ-028 Wrap: frame 0x0F,0x11,0x22 -> reg15=0x11, reg0=0x22; read frame 0x8F,x,x returns 0x11,0x22.
REQ-029 Abort: frame 0x05 then 4 bits of 0xFF, then CS_n high -> reg5 unchanged, no toggle, next frame decodes a fresh command.
REQ-030 Reset mid-read: assert i_Rst_L low after 3 bits of the data word -> all outputs 0, o_Reg_Flat all 0, MISO 1 once CS_n is high.
REQ-031 AUTOINC undefined: frame 0x02,0x10,0x20 -> reg2=0x20, reg3 unchanged, toggle twice.
